// File: rtl/uart_tx_queue_if.sv
// Handshake bundle shared by the character producer, the transmit queue and the UART transmitter.
// The slave view belongs to the queue; the master view drives writes, flow control and busy.
interface uart_tx_queue_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
);
  localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] Wr_Data;
  logic                 Wr_En;
  logic                 CTS;
  logic                 Tx_Busy;
  logic [DATA_BITS-1:0] Tx_Data;
  logic                 Transmit_Start;
  logic                 Queue_Empty;
  logic                 Queue_Full;
  logic                 Queue_Overflow;
  logic [COUNT_W-1:0]   Queue_Count;

  modport master (
    output Wr_Data, Wr_En, CTS, Tx_Busy,
    input  Tx_Data, Transmit_Start, Queue_Empty, Queue_Full, Queue_Overflow, Queue_Count
  );

  modport slave (
    input  Wr_Data, Wr_En, CTS, Tx_Busy,
    output Tx_Data, Transmit_Start, Queue_Empty, Queue_Full, Queue_Overflow, Queue_Count
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Character queue in front of a UART transmitter: circular buffer plus a launch FSM that
// hands one character at a time to the transmitter under CTS flow control.
module uart_tx_queue #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic            SysClk,
  input logic            Rst,
  uart_tx_queue_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 empty_q;
  logic                 full_q;
  logic                 overflow_q;
  logic                 start_q;
  logic [DATA_BITS-1:0] tx_data_q;
  logic                 push;
  logic                 pop;
  logic                 start_next;

  // Full is the registered flag, so a write into a full queue is dropped even if a pop
  // frees a slot on the same edge.
  assign push = bus.Wr_En && !full_q;

  always_ff @(posedge SysClk) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // Transmit_Start stays up through WAIT_BUSY so a transmitter on a slow baud clock still sees it.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start_next = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_q && bus.CTS && !bus.Tx_Busy) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (bus.Tx_Busy)  state_next = WAIT_DONE;
      WAIT_DONE: if (!bus.Tx_Busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    start_next = (state_next == START) || (state_next == WAIT_BUSY);
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge SysClk) begin
    if (Rst && push) mem[wr_ptr] <= bus.Wr_Data;
  end

  always_ff @(posedge SysClk) begin
    if (!Rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      start_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        tx_data_q <= mem[rd_ptr];
      end
      if (bus.Wr_En && full_q) overflow_q <= 1'b1;
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == CNT_W'(FIFO_DEPTH));
      start_q <= start_next;
    end
  end

  assign bus.Tx_Data        = tx_data_q;
  assign bus.Transmit_Start = start_q;
  assign bus.Queue_Empty    = empty_q;
  assign bus.Queue_Full     = full_q;
  assign bus.Queue_Overflow = overflow_q;
  assign bus.Queue_Count    = count;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a FIFO reference model, a behavioural transmitter and a launch
// monitor that checks every launched character against the model's queue head.
module tb_uart_tx_queue;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 8;

  logic SysClk = 1'b0;
  logic Rst;

  uart_tx_queue_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_tx_queue #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .SysClk(SysClk),
    .Rst   (Rst),
    .bus   (bus)
  );

  always #5 SysClk = ~SysClk;

  int                   total = 0;
  int                   bad = 0;
  logic [DATA_BITS-1:0] model_q[$];
  bit                   model_ovf = 1'b0;
  int                   launches = 0;
  int                   ts_high_cycles = 0;
  bit                   ts_prev = 1'b0;
  logic [DATA_BITS-1:0] last_launched = '0;
  bit                   tx_enable = 1'b1;
  bit                   xmtr_active = 1'b0;
  int                   busy_delay = 3;
  int                   busy_len = 10;

  // Every launch must present the oldest modelled character and hold it until the next launch.
  initial begin : monitor
    logic [DATA_BITS-1:0] exp_d;
    forever begin
      @(posedge SysClk);
      #2;
      if (bus.Transmit_Start === 1'b1) ts_high_cycles++;
      if (bus.Transmit_Start === 1'b1 && !ts_prev) begin
        launches++;
        total++;
        if (model_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL launch_order: got launch of %02h, expected no launch (model queue empty)", bus.Tx_Data);
        end else begin
          exp_d = model_q.pop_front();
          last_launched = exp_d;
          if (bus.Tx_Data !== exp_d) begin
            bad++;
            $display("[TB] FAIL launch_order: Tx_Data=%02h expected %02h", bus.Tx_Data, exp_d);
          end
        end
      end else if (bus.Transmit_Start === 1'b1 || bus.Tx_Busy === 1'b1) begin
        total++;
        if (bus.Tx_Data !== last_launched) begin
          bad++;
          $display("[TB] FAIL tx_data_stable: Tx_Data=%02h expected %02h", bus.Tx_Data, last_launched);
        end
      end
      ts_prev = (bus.Transmit_Start === 1'b1);
    end
  end

  // Transmitter: raises busy busy_delay cycles after seeing the launch and holds it busy_len cycles.
  initial begin : xmtr
    bus.Tx_Busy = 1'b0;
    forever begin
      @(posedge SysClk);
      #4;
      if (tx_enable && bus.Transmit_Start === 1'b1 && !bus.Tx_Busy) begin
        xmtr_active = 1'b1;
        repeat (busy_delay) @(posedge SysClk);
        #4 bus.Tx_Busy = 1'b1;
        repeat (busy_len) @(posedge SysClk);
        #4 bus.Tx_Busy = 1'b0;
        xmtr_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic write_char(input logic [DATA_BITS-1:0] d);
    bus.Wr_Data = d;
    bus.Wr_En   = 1'b1;
    @(posedge SysClk);
    #1;
    bus.Wr_En = 1'b0;
    if (model_q.size() == FIFO_DEPTH) model_ovf = 1'b1;
    else model_q.push_back(d);
  endtask

  task automatic do_reset();
    Rst       = 1'b0;
    bus.Wr_En = 1'b0;
    @(posedge SysClk);
    #1;
    Rst = 1'b1;
    model_q.delete();
    model_ovf = 1'b0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge SysClk);
      #3;
      if (model_q.size() == 0 && bus.Transmit_Start === 1'b0 && bus.Tx_Busy === 1'b0 && !xmtr_active) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge SysClk);
    #3;
  endtask

  task automatic wait_xmtr_quiet(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge SysClk);
      #3;
      if (!xmtr_active && bus.Tx_Busy === 1'b0 && bus.Transmit_Start === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge SysClk);
    #3;
  endtask

  task automatic test_reset();
    Rst         = 1'b0;
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = 8'h5A;
    bus.CTS     = 1'b1;
    repeat (3) @(posedge SysClk);
    #1;
    total++; if (bus.Queue_Count !== 4'd0)       begin bad++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.Queue_Count); end
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL reset_empty: got %b expected 1", bus.Queue_Empty); end
    total++; if (bus.Queue_Full !== 1'b0)        begin bad++; $display("[TB] FAIL reset_full: got %b expected 0", bus.Queue_Full); end
    total++; if (bus.Queue_Overflow !== 1'b0)    begin bad++; $display("[TB] FAIL reset_overflow: got %b expected 0", bus.Queue_Overflow); end
    total++; if (bus.Transmit_Start !== 1'b0)    begin bad++; $display("[TB] FAIL reset_start: got %b expected 0", bus.Transmit_Start); end
    total++; if (bus.Tx_Data !== 8'h00)          begin bad++; $display("[TB] FAIL reset_txdata: got %02h expected 00", bus.Tx_Data); end
    bus.Wr_En = 1'b0;
    bus.CTS   = 1'b0;
    Rst       = 1'b1;
    @(posedge SysClk);
    #1;
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL reset_write_ignored: Queue_Empty=%b expected 1", bus.Queue_Empty); end
  endtask

  task automatic test_single();
    bit ok;
    int base;
    busy_delay     = 3;
    busy_len       = 10;
    bus.CTS        = 1'b1;
    base           = launches;
    ts_high_cycles = 0;
    write_char(8'hA5);
    total++; if (bus.Transmit_Start !== 1'b0)    begin bad++; $display("[TB] FAIL single_early_start: got %b expected 0", bus.Transmit_Start); end
    total++; if (bus.Queue_Count !== 4'd1)       begin bad++; $display("[TB] FAIL single_count_after_write: got %0d expected 1", bus.Queue_Count); end
    drain(200, ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL single_drain: timed out, expected completion"); end
    total++; if (ts_high_cycles != 4)            begin bad++; $display("[TB] FAIL single_start_width: got %0d cycles expected 4", ts_high_cycles); end
    total++; if (launches - base != 1)           begin bad++; $display("[TB] FAIL single_launches: got %0d expected 1", launches - base); end
    total++; if (bus.Queue_Count !== 4'd0)       begin bad++; $display("[TB] FAIL single_count_end: got %0d expected 0", bus.Queue_Count); end
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL single_empty_end: got %b expected 1", bus.Queue_Empty); end
  endtask

  task automatic test_fill_order();
    bit ok;
    int base;
    do_reset();
    busy_delay = 1;
    busy_len   = 2;
    bus.CTS    = 1'b0;
    base       = launches;
    for (int i = 1; i <= 8; i++) write_char(8'(i));
    #2;
    total++; if (bus.Queue_Full !== 1'b1)        begin bad++; $display("[TB] FAIL fill_full: got %b expected 1", bus.Queue_Full); end
    total++; if (bus.Queue_Count !== 4'd8)       begin bad++; $display("[TB] FAIL fill_count: got %0d expected 8", bus.Queue_Count); end
    total++; if (bus.Queue_Overflow !== 1'b0)    begin bad++; $display("[TB] FAIL fill_no_overflow: got %b expected 0", bus.Queue_Overflow); end
    write_char(8'h09);
    #2;
    total++; if (bus.Queue_Overflow !== model_ovf) begin bad++; $display("[TB] FAIL fill_overflow: got %b expected %b", bus.Queue_Overflow, model_ovf); end
    total++; if (bus.Queue_Count !== 4'd8)       begin bad++; $display("[TB] FAIL fill_count_after_drop: got %0d expected 8", bus.Queue_Count); end
    bus.CTS = 1'b1;
    drain(400, ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL fill_drain: timed out, expected completion"); end
    total++; if (launches - base != 8)           begin bad++; $display("[TB] FAIL fill_launches: got %0d expected 8", launches - base); end
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL fill_empty_end: got %b expected 1", bus.Queue_Empty); end
    total++; if (bus.Queue_Overflow !== 1'b1)    begin bad++; $display("[TB] FAIL fill_overflow_sticky: got %b expected 1", bus.Queue_Overflow); end
  endtask

  task automatic test_wrap();
    bit ok;
    int base;
    int written;
    int cycles;
    do_reset();
    bus.CTS    = 1'b1;
    busy_delay = 1;
    base       = launches;
    written    = 0;
    cycles     = 0;
    while (written < 20 && cycles < 2000) begin
      if (model_q.size() < 4 && $urandom_range(0, 2) != 0) begin
        busy_len = int'($urandom_range(1, 4));
        write_char(8'($urandom));
        written++;
      end else begin
        @(posedge SysClk);
        #1;
      end
      #2;
      total++;
      if (bus.Queue_Count !== 4'(model_q.size()) || bus.Queue_Count > 4'd5) begin
        bad++;
        $display("[TB] FAIL wrap_count: got %0d expected %0d (at most 5)", bus.Queue_Count, model_q.size());
      end
      cycles++;
    end
    total++; if (written != 20)                  begin bad++; $display("[TB] FAIL wrap_written: got %0d expected 20", written); end
    drain(400, ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL wrap_drain: timed out, expected completion"); end
    total++; if (launches - base != 20)          begin bad++; $display("[TB] FAIL wrap_launches: got %0d expected 20", launches - base); end
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL wrap_empty_end: got %b expected 1", bus.Queue_Empty); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int base;
    do_reset();
    busy_delay = 2;
    busy_len   = 3;
    bus.CTS    = 1'b0;
    base       = launches;
    for (int i = 0; i < 3; i++) write_char(8'($urandom));
    #2;
    total++; if (bus.Queue_Count !== 4'd3)       begin bad++; $display("[TB] FAIL simul_pre_count: got %0d expected 3", bus.Queue_Count); end
    bus.CTS = 1'b1;
    write_char(8'($urandom));
    bus.CTS = 1'b0;
    #2;
    total++; if (bus.Queue_Count !== 4'd3)       begin bad++; $display("[TB] FAIL simul_push_pop_count: got %0d expected 3", bus.Queue_Count); end
    total++; if (launches - base != 1)           begin bad++; $display("[TB] FAIL simul_pop_happened: got %0d launches expected 1", launches - base); end
    wait_xmtr_quiet(ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL simul_quiet: timed out, expected transmitter idle"); end
    while (model_q.size() < FIFO_DEPTH) write_char(8'($urandom));
    #2;
    total++; if (bus.Queue_Full !== 1'b1)        begin bad++; $display("[TB] FAIL simul_full: got %b expected 1", bus.Queue_Full); end
    bus.CTS = 1'b1;
    write_char(8'hEE);
    bus.CTS = 1'b0;
    #2;
    total++; if (bus.Queue_Count !== 4'd7)       begin bad++; $display("[TB] FAIL simul_full_pop_count: got %0d expected 7", bus.Queue_Count); end
    total++; if (bus.Queue_Overflow !== model_ovf) begin bad++; $display("[TB] FAIL simul_full_overflow: got %b expected %b", bus.Queue_Overflow, model_ovf); end
    total++; if (bus.Queue_Full !== 1'b0)        begin bad++; $display("[TB] FAIL simul_not_full: got %b expected 0", bus.Queue_Full); end
    bus.CTS = 1'b1;
    drain(400, ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL simul_drain: timed out, expected completion"); end
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL simul_empty_end: got %b expected 1", bus.Queue_Empty); end
  endtask

  task automatic test_flow();
    bit ok;
    int base;
    do_reset();
    busy_delay = 1;
    busy_len   = 6;
    bus.CTS    = 1'b1;
    base       = launches;
    write_char(8'($urandom));
    write_char(8'($urandom));
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge SysClk);
      #3;
      if (bus.Tx_Busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL flow_busy_seen: timed out, expected Tx_Busy"); end
    bus.CTS = 1'b0;
    wait_xmtr_quiet(ok);
    repeat (10) @(posedge SysClk);
    #3;
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL flow_first_done: timed out, expected completion"); end
    total++; if (launches - base != 1)           begin bad++; $display("[TB] FAIL flow_blocked: got %0d launches expected 1", launches - base); end
    total++; if (bus.Queue_Count !== 4'd1)       begin bad++; $display("[TB] FAIL flow_count_held: got %0d expected 1", bus.Queue_Count); end
    total++; if (bus.Transmit_Start !== 1'b0)    begin bad++; $display("[TB] FAIL flow_no_start: got %b expected 0", bus.Transmit_Start); end
    bus.CTS = 1'b1;
    drain(200, ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL flow_drain: timed out, expected completion"); end
    total++; if (launches - base != 2)           begin bad++; $display("[TB] FAIL flow_resumed: got %0d launches expected 2", launches - base); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    do_reset();
    tx_enable = 1'b0;
    bus.CTS   = 1'b0;
    for (int i = 0; i < 5; i++) write_char(8'($urandom));
    bus.CTS = 1'b1;
    repeat (3) @(posedge SysClk);
    #3;
    total++; if (bus.Transmit_Start !== 1'b1)    begin bad++; $display("[TB] FAIL rstmid_in_wait_busy: Transmit_Start=%b expected 1", bus.Transmit_Start); end
    total++; if (bus.Queue_Count !== 4'd4)       begin bad++; $display("[TB] FAIL rstmid_pre_count: got %0d expected 4", bus.Queue_Count); end
    Rst         = 1'b0;
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = 8'hFF;
    @(posedge SysClk);
    #1;
    Rst       = 1'b1;
    bus.Wr_En = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    total++; if (bus.Transmit_Start !== 1'b0)    begin bad++; $display("[TB] FAIL rstmid_start: got %b expected 0", bus.Transmit_Start); end
    total++; if (bus.Queue_Count !== 4'd0)       begin bad++; $display("[TB] FAIL rstmid_count: got %0d expected 0", bus.Queue_Count); end
    total++; if (bus.Queue_Empty !== 1'b1)       begin bad++; $display("[TB] FAIL rstmid_empty: got %b expected 1", bus.Queue_Empty); end
    total++; if (bus.Queue_Overflow !== 1'b0)    begin bad++; $display("[TB] FAIL rstmid_overflow: got %b expected 0", bus.Queue_Overflow); end
    tx_enable  = 1'b1;
    busy_delay = 2;
    busy_len   = 4;
    base       = launches;
    write_char(8'h3C);
    drain(200, ok);
    total++; if (!ok)                            begin bad++; $display("[TB] FAIL rstmid_drain: timed out, expected completion"); end
    total++; if (launches - base != 1)           begin bad++; $display("[TB] FAIL rstmid_launches: got %0d expected 1", launches - base); end
  endtask

  initial begin : main
    Rst         = 1'b0;
    bus.Wr_En   = 1'b0;
    bus.Wr_Data = '0;
    bus.CTS     = 1'b0;
    test_reset();
    test_single();
    test_fill_order();
    test_wrap();
    test_simultaneous();
    test_flow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
